// File: rtl/mc_control.sv
// Multicycle LEGv8 control unit: Moore sequencer for the shared-datapath core,
// with a memory-ready stall handshake and a retired-instruction counter.
module mc_control #(
    parameter int INSTRET_W = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [10:0]          op,
    input  logic                 zero,
    input  logic                 mem_ready,
    output logic                 pcwrite,
    output logic                 pcsrc,
    output logic                 iord,
    output logic                 memread,
    output logic                 memwrite,
    output logic                 irwrite,
    output logic                 reg2loc,
    output logic                 regwrite,
    output logic                 memtoreg,
    output logic                 alusrca,
    output logic [1:0]           alusrcb,
    output logic [1:0]           aluop,
    output logic                 illegal,
    output logic [3:0]           state,
    output logic [INSTRET_W-1:0] instret
);

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADDR = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_EXEC    = 4'd6,
        S_RWB     = 4'd7,
        S_CBZ     = 4'd8,
        S_BRANCH  = 4'd9
    } state_t;

    state_t                 r_state;
    state_t                 w_next;
    logic                   w_retire;
    logic [INSTRET_W-1:0]   r_instret;

    logic w_is_ldur;
    logic w_is_stur;
    logic w_is_cbz;
    logic w_is_b;
    logic w_is_rtype;
    logic w_r2l;

    assign w_is_ldur  = (op == 11'b11111000010);
    assign w_is_stur  = (op == 11'b11111000000);
    assign w_is_cbz   = (op[10:3] == 8'b10110100);
    assign w_is_b     = (op[10:5] == 6'b000101);
    assign w_is_rtype = (op == 11'b10001011000) || (op == 11'b11001011000) ||
                        (op == 11'b10001010000) || (op == 11'b10101010000);
    assign w_r2l      = w_is_stur || w_is_cbz;

    // Next-state and retirement: retiring is exactly a completed return to FETCH
    always_comb begin
        w_next   = S_FETCH;
        w_retire = 1'b0;
        case (r_state)
            S_FETCH:   w_next = mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                if (w_is_ldur || w_is_stur) w_next = S_MEMADDR;
                else if (w_is_rtype)        w_next = S_EXEC;
                else if (w_is_cbz)          w_next = S_CBZ;
                else if (w_is_b)            w_next = S_BRANCH;
                else                        w_next = S_FETCH;
            end
            S_MEMADDR: begin
                if (w_is_ldur)      w_next = S_MEMRD;
                else if (w_is_stur) w_next = S_MEMWR;
                else                w_next = S_FETCH;
            end
            S_MEMRD:   w_next = mem_ready ? S_MEMWB : S_MEMRD;
            S_MEMWB: begin
                w_next   = S_FETCH;
                w_retire = 1'b1;
            end
            S_MEMWR: begin
                w_next   = mem_ready ? S_FETCH : S_MEMWR;
                w_retire = mem_ready;
            end
            S_EXEC:    w_next = S_RWB;
            S_RWB: begin
                w_next   = S_FETCH;
                w_retire = 1'b1;
            end
            S_CBZ: begin
                w_next   = S_FETCH;
                w_retire = 1'b1;
            end
            S_BRANCH: begin
                w_next   = S_FETCH;
                w_retire = 1'b1;
            end
            default:   w_next = S_FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= S_FETCH;
            r_instret <= '0;
        end else begin
            r_state <= w_next;
            if (w_retire)
                r_instret <= r_instret + {{(INSTRET_W-1){1'b0}}, 1'b1};
        end
    end

    // Moore outputs; the reset gate keeps every strobe low during a reset cycle
    always_comb begin
        pcwrite  = 1'b0;
        pcsrc    = 1'b0;
        iord     = 1'b0;
        memread  = 1'b0;
        memwrite = 1'b0;
        irwrite  = 1'b0;
        reg2loc  = 1'b0;
        regwrite = 1'b0;
        memtoreg = 1'b0;
        alusrca  = 1'b0;
        alusrcb  = 2'b00;
        aluop    = 2'b00;
        illegal  = 1'b0;
        if (!reset) begin
            case (r_state)
                S_FETCH: begin
                    memread = 1'b1;
                    alusrcb = 2'b01;
                    if (mem_ready) begin
                        irwrite = 1'b1;
                        pcwrite = 1'b1;
                    end
                end
                S_DECODE: begin
                    reg2loc = w_r2l;
                    alusrcb = 2'b11;
                    illegal = !(w_is_ldur || w_is_stur || w_is_rtype || w_is_cbz || w_is_b);
                end
                S_MEMADDR: begin
                    reg2loc = w_r2l;
                    alusrca = 1'b1;
                    alusrcb = 2'b10;
                end
                S_MEMRD: begin
                    reg2loc = w_r2l;
                    memread = 1'b1;
                    iord    = 1'b1;
                end
                S_MEMWB: begin
                    reg2loc  = w_r2l;
                    regwrite = 1'b1;
                    memtoreg = 1'b1;
                end
                S_MEMWR: begin
                    reg2loc  = w_r2l;
                    memwrite = 1'b1;
                    iord     = 1'b1;
                end
                S_EXEC: begin
                    reg2loc = w_r2l;
                    alusrca = 1'b1;
                    aluop   = 2'b10;
                end
                S_RWB: begin
                    reg2loc  = w_r2l;
                    regwrite = 1'b1;
                end
                S_CBZ: begin
                    reg2loc = w_r2l;
                    alusrca = 1'b1;
                    aluop   = 2'b01;
                    pcsrc   = 1'b1;
                    pcwrite = zero;
                end
                S_BRANCH: begin
                    reg2loc = w_r2l;
                    pcwrite = 1'b1;
                    pcsrc   = 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign state   = reset ? 4'd0 : r_state;
    assign instret = reset ? '0 : r_instret;

endmodule

// File: tb/tb_mc_control.sv
// Randomized bench for mc_control: per-instruction expected state sequences and
// control words built from the instruction class, with a narrow counter to exercise wrap.
module tb_mc_control;

    localparam int IW = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic [10:0]   op;
    logic          zero;
    logic          mem_ready;
    logic          pcwrite, pcsrc, iord, memread, memwrite, irwrite, reg2loc;
    logic          regwrite, memtoreg, alusrca, illegal;
    logic [1:0]    alusrcb, aluop;
    logic [3:0]    state;
    logic [IW-1:0] instret;

    mc_control #(.INSTRET_W(IW)) dut (
        .clk(clk), .reset(reset), .op(op), .zero(zero), .mem_ready(mem_ready),
        .pcwrite(pcwrite), .pcsrc(pcsrc), .iord(iord), .memread(memread),
        .memwrite(memwrite), .irwrite(irwrite), .reg2loc(reg2loc),
        .regwrite(regwrite), .memtoreg(memtoreg), .alusrca(alusrca),
        .alusrcb(alusrcb), .aluop(aluop), .illegal(illegal),
        .state(state), .instret(instret)
    );

    always #5 clk = ~clk;

    localparam int C_LDUR = 0, C_STUR = 1, C_CBZ = 2, C_B = 3, C_R = 4, C_ILL = 5;

    typedef struct {
        int   st;
        logic rdy;
        logic z;
    } step_t;

    int            checks = 0;
    int            fails  = 0;
    logic [IW-1:0] exp_ir = '0;
    step_t         q[$];

    function automatic int classify(input logic [10:0] o);
        if (o == 11'b11111000010) return C_LDUR;
        if (o == 11'b11111000000) return C_STUR;
        if (o[10:3] == 8'b10110100) return C_CBZ;
        if (o[10:5] == 6'b000101) return C_B;
        if (o == 11'b10001011000 || o == 11'b11001011000 ||
            o == 11'b10001010000 || o == 11'b10101010000) return C_R;
        return C_ILL;
    endfunction

    // Packed as {pcwrite,pcsrc,iord,memread,memwrite,irwrite,reg2loc,regwrite,memtoreg,alusrca,alusrcb,aluop,illegal}
    function automatic logic [14:0] ctrl(input int st, input int cls, input logic z, input logic rdy);
        logic pw, ps, io, mr, mw, iw, r2, rw, mt, sa, il;
        logic [1:0] sb, ao;
        {pw, ps, io, mr, mw, iw, r2, rw, mt, sa, il} = '0;
        sb = 2'b00;
        ao = 2'b00;
        if (st != 0) r2 = (cls == C_STUR || cls == C_CBZ);
        case (st)
            0: begin mr = 1; sb = 2'b01; pw = rdy; iw = rdy; end
            1: begin sb = 2'b11; il = (cls == C_ILL); end
            2: begin sa = 1; sb = 2'b10; end
            3: begin mr = 1; io = 1; end
            4: begin rw = 1; mt = 1; end
            5: begin mw = 1; io = 1; end
            6: begin sa = 1; ao = 2'b10; end
            7: begin rw = 1; end
            8: begin sa = 1; ao = 2'b01; ps = 1; pw = z; end
            9: begin pw = 1; ps = 1; end
            default: ;
        endcase
        return {pw, ps, io, mr, mw, iw, r2, rw, mt, sa, sb, ao, il};
    endfunction

    task automatic cycle(input logic r, input logic [10:0] o, input logic z, input logic rdy,
                         input int est, input logic [14:0] ectl, input string tag);
        logic [14:0] got;
        @(negedge clk);
        reset = r; op = o; zero = z; mem_ready = rdy;
        #1;
        got = {pcwrite, pcsrc, iord, memread, memwrite, irwrite, reg2loc,
               regwrite, memtoreg, alusrca, alusrcb, aluop, illegal};
        checks++;
        assert (state === 4'(est)) else begin
            fails++;
            $error("FAIL %s state observed=%0d expected=%0d", tag, state, est);
        end
        checks++;
        assert (got === ectl) else begin
            fails++;
            $error("FAIL %s ctrl(state %0d) observed=%b expected=%b", tag, est, got, ectl);
        end
        checks++;
        assert (instret === exp_ir) else begin
            fails++;
            $error("FAIL %s instret observed=%0d expected=%0d", tag, instret, exp_ir);
        end
    endtask

    // Expected cycle sequence for one instruction; zf < 0 means random zero flag
    task automatic run_instr(input logic [10:0] o, input int fw, input int mw, input int zf, input string tag);
        int cls;
        step_t s;
        cls = classify(o);
        q.delete();
        for (int i = 0; i < fw; i++) begin s.st = 0; s.rdy = 0; s.z = 1'($urandom); q.push_back(s); end
        s.st = 0; s.rdy = 1; s.z = 1'($urandom); q.push_back(s);
        s.st = 1; s.rdy = 1'($urandom); q.push_back(s);
        case (cls)
            C_LDUR, C_STUR: begin
                s.st = 2; s.rdy = 1'($urandom); q.push_back(s);
                for (int i = 0; i < mw; i++) begin
                    s.st = (cls == C_LDUR) ? 3 : 5; s.rdy = 0; s.z = 1'($urandom); q.push_back(s);
                end
                s.st = (cls == C_LDUR) ? 3 : 5; s.rdy = 1; q.push_back(s);
                if (cls == C_LDUR) begin s.st = 4; s.rdy = 1'($urandom); q.push_back(s); end
            end
            C_R: begin
                s.st = 6; s.rdy = 1'($urandom); q.push_back(s);
                s.st = 7; s.rdy = 1'($urandom); q.push_back(s);
            end
            C_CBZ: begin
                s.st = 8; s.rdy = 1'($urandom);
                s.z = (zf < 0) ? 1'($urandom) : 1'(zf);
                q.push_back(s);
            end
            C_B: begin s.st = 9; s.rdy = 1'($urandom); q.push_back(s); end
            default: ;
        endcase
        foreach (q[i]) begin
            cycle(1'b0, o, q[i].z, q[i].rdy, q[i].st, ctrl(q[i].st, cls, q[i].z, q[i].rdy), tag);
            if (i == q.size() - 1 && cls != C_ILL) exp_ir = exp_ir + 1'b1;
        end
    endtask

    task automatic do_reset(input int n, input logic [10:0] o);
        for (int i = 0; i < n; i++) begin
            exp_ir = '0;
            cycle(1'b1, o, 1'($urandom), 1'($urandom), 0, 15'd0, "reset");
        end
    endtask

    initial begin
        logic [10:0] o;
        int k;
        logic [10:0] rops [4];
        rops[0] = 11'b10001011000; rops[1] = 11'b11001011000;
        rops[2] = 11'b10001010000; rops[3] = 11'b10101010000;
        reset = 1'b1; op = '0; zero = 1'b0; mem_ready = 1'b0;

        do_reset(3, 11'b0);

        // LDUR interrupted by reset while waiting in MEMRD
        o = 11'b11111000010;
        cycle(1'b0, o, 1'b0, 1'b1, 0, ctrl(0, C_LDUR, 0, 1), "ldur_abort");
        cycle(1'b0, o, 1'b0, 1'b0, 1, ctrl(1, C_LDUR, 0, 0), "ldur_abort");
        cycle(1'b0, o, 1'b0, 1'b0, 2, ctrl(2, C_LDUR, 0, 0), "ldur_abort");
        cycle(1'b0, o, 1'b0, 1'b0, 3, ctrl(3, C_LDUR, 0, 0), "ldur_abort");
        do_reset(3, o);

        run_instr(11'b10001011000, 0, 0, -1, "add");
        run_instr(11'b11111000010, 0, 2, -1, "ldur_wait");
        run_instr(11'b11111000000, 1, 1, -1, "stur_wait");
        run_instr(11'b10110100101, 0, 0, 1, "cbz_taken");
        run_instr(11'b10110100010, 0, 0, 0, "cbz_not");
        run_instr(11'b00000000000, 0, 0, -1, "illegal");

        // Counter wrap: 16 branches from a fresh reset
        do_reset(2, 11'b0);
        for (int i = 0; i < 16; i++) begin
            o = {6'b000101, 5'($urandom)};
            run_instr(o, 0, 0, -1, "b_wrap");
        end
        checks++;
        assert (exp_ir === '0) else begin
            fails++;
            $error("FAIL wrap_model observed=%0d expected=0", exp_ir);
        end
        cycle(1'b0, 11'b0, 1'b0, 1'b0, 0, ctrl(0, C_ILL, 0, 0), "wrap_zero");

        for (int n = 0; n < 150; n++) begin
            k = $urandom_range(0, 5);
            case (k)
                0: o = 11'b11111000010;
                1: o = 11'b11111000000;
                2: o = {8'b10110100, 3'($urandom)};
                3: o = {6'b000101, 5'($urandom)};
                4: o = rops[$urandom_range(0, 3)];
                default: o = 11'($urandom);
            endcase
            run_instr(o, $urandom_range(0, 2), $urandom_range(0, 3), -1, "rand");
        end

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule

// File: doc/mc_control.md
# mc_control

Multicycle control unit for the LEGv8 core: a Moore state machine that sequences the shared datapath (single ALU, unified memory, IR/A/B/ALUOut registers) through fetch, decode, execute, memory and writeback steps. It drives `aluop` into the existing ALU control decoder and all datapath enables/muxes. It stalls on a memory ready handshake and counts retired instructions.

## Interface
- `INSTRET_W`, 32: width of the retired-instruction counter.
- `clk` in 1: rising-edge clock.
- `reset` in 1: reset, synchronous, active-high.
- `op` in 11: IR[31:21], stable from DECODE until the return to FETCH.
- `zero` in 1: ALU zero flag (combinational, current cycle).
- `mem_ready` in 1: memory completes the current access this cycle.
- `pcwrite` out 1: PC load enable.
- `pcsrc` out 1: 0 = ALU result (PC+4), 1 = ALUOut (branch target).
- `iord` out 1: memory address, 0 = PC, 1 = ALUOut.
- `memread`, `memwrite` out 1: memory request strobes, held until `mem_ready`.
- `irwrite` out 1: IR load enable.
- `reg2loc` out 1: register read port 2 selects Rt (1) or Rm (0).
- `regwrite` out 1: register file write enable.
- `memtoreg` out 1: writeback, 0 = ALUOut, 1 = memory data register.
- `alusrca` out 1: 0 = PC, 1 = A.
- `alusrcb` out 2: 00 = B, 01 = constant 4, 10 = sign-extended D offset, 11 = branch offset << 2.
- `aluop` out 2: 00 add, 01 pass B, 10 funct-decoded.
- `illegal` out 1: unrecognised opcode in DECODE.
- `state` out 4: current state encoding (debug).
- `instret` out INSTRET_W: count of retired instructions.

## Operation
- Decoded classes: LDUR op=11111000010; STUR op=11111000000; CBZ op[10:3]=10110100; B op[10:5]=000101; R-type op ∈ {10001011000 ADD, 11001011000 SUB, 10001010000 AND, 10101010000 ORR}; anything else is illegal.
- `reg2loc` = 1 when op is STUR or CBZ in every state except FETCH; 0 otherwise.
- Unlisted outputs are 0 in each state.
- States (encoding): FETCH 0, DECODE 1, MEMADDR 2, MEMRD 3, MEMWB 4, MEMWR 5, EXEC 6, RWB 7, CBZ 8, BRANCH 9.
- FETCH: memread=1, iord=0, alusrca=0, alusrcb=01, aluop=00. When `mem_ready`=1: irwrite=1, pcwrite=1, pcsrc=0, next = DECODE. Otherwise hold.
- DECODE: alusrca=0, alusrcb=11, aluop=00 (branch target into ALUOut). Next state:
  - LDUR/STUR -> MEMADDR
  - R-type -> EXEC
  - CBZ -> CBZ
  - B -> BRANCH
  - illegal -> FETCH with `illegal`=1 for this cycle.
- MEMADDR: alusrca=1, alusrcb=10, aluop=00. Next state: LDUR -> MEMRD, STUR -> MEMWR.
- MEMRD: memread=1, iord=1. Hold until `mem_ready`, then -> MEMWB.
- MEMWB: regwrite=1, memtoreg=1. Next = FETCH.
- MEMWR: memwrite=1, iord=1. Hold until `mem_ready`, then -> FETCH.
- EXEC: alusrca=1, alusrcb=00, aluop=10. Next = RWB.
- RWB: regwrite=1, memtoreg=0. Next = FETCH.
- CBZ: alusrca=1, alusrcb=00, aluop=01, pcsrc=1, pcwrite=`zero`. Next = FETCH.
- BRANCH: pcwrite=1, pcsrc=1. Next = FETCH.
- `instret` increments by 1, wrapping modulo 2^INSTRET_W, on each transition into FETCH from MEMWB, MEMWR (on ready), RWB, CBZ or BRANCH. Illegal opcodes do not retire.
- Unused encodings 10–15 -> FETCH next cycle; all outputs 0 while in them.

## Timing
- While `reset`=1, all outputs are 0, `state` is 0 and `instret` is 0. The first cycle after deassertion is FETCH with memread=1.
- Reset mid-operation (including during a pending memory access) aborts the instruction; no write strobes are asserted in the reset cycle.
- Outputs are combinational from the state register, `op` and `zero`/`mem_ready` only where listed above. The state register and `instret` update on the rising edge.
- Cycle counts with zero wait states:
  - R-type: 4
  - LDUR: 5
  - STUR: 4
  - CBZ: 3
  - B: 3
  - illegal: 2
- Each wait cycle with `mem_ready`=0 in FETCH, MEMRD or MEMWR adds one cycle. Request strobes stay asserted and stable throughout.
- `mem_ready` in any other state is ignored.

## Test plan
- Reset held 3 cycles mid-MEMRD -> all outputs 0 and instret=0 during reset; FETCH with memread=1 on the first cycle after release.
- ADD (op=10001011000), mem_ready always 1 -> states 0,1,6,7,0; aluop=10 in EXEC; regwrite=1 only in RWB; instret +1.
- LDUR with mem_ready low 2 cycles in MEMRD -> states 0,1,2,3,3,3,4,0; memread and iord held 1 for 3 cycles; memtoreg=1 in MEMWB.
- CBZ with zero=1, then CBZ with zero=0 -> pcwrite=1/pcsrc=1 in the first CBZ state, pcwrite=0 in the second; both retire (instret +2).
- op=00000000000 -> `illegal`=1 for one DECODE cycle, returns to FETCH, instret unchanged, no regwrite/memwrite.
- INSTRET_W=4, 16 B instructions from instret=0 -> instret wraps to 0.
